// File: rtl/imm_pkg.sv
// Shared opcode constants, immediate format codes and skid states
// for the registered immediate-extraction stage.
package imm_pkg;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_FENCE   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5,
        FMT_Z = 3'd6
    } imm_fmt_t;

    typedef enum logic [1:0] {
        SK_EMPTY = 2'd0,
        SK_ONE   = 2'd1,
        SK_TWO   = 2'd2
    } skid_state_t;

endpackage

// File: rtl/imm_decode_core.sv
// Combinational instruction -> immediate/format/illegal decoder.
// All immediates are built as 32-bit signed values, then sign-extended.
module imm_decode_core
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     insn,
    output logic [XLEN-1:0] imm,
    output imm_fmt_t        fmt,
    output logic            illegal
);

    localparam bit RV64 = (XLEN == 64);

    logic [6:0]         opc;
    logic [2:0]         f3;
    logic               wide_shamt;
    logic signed [31:0] imm32;
    logic signed [31:0] i_imm;
    logic signed [31:0] s_imm;
    logic signed [31:0] b_imm;
    logic signed [31:0] u_imm;
    logic signed [31:0] j_imm;
    logic signed [31:0] z_imm;

    assign opc = insn[6:0];
    assign f3  = insn[14:12];

    assign wide_shamt = ((f3 == 3'b001) || (f3 == 3'b101)) && insn[25];

    assign i_imm = {{20{insn[31]}}, insn[31:20]};
    assign s_imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
    assign b_imm = {{19{insn[31]}}, insn[31], insn[7],
                    insn[30:25], insn[11:8], 1'b0};
    assign u_imm = {insn[31:12], 12'b0};
    assign j_imm = {{11{insn[31]}}, insn[31], insn[19:12],
                    insn[20], insn[30:21], 1'b0};
    assign z_imm = {27'b0, insn[19:15]};

    // Opcode decode; unknown opcodes yield a clean zero result
    always_comb begin
        imm32   = '0;
        fmt     = FMT_R;
        illegal = 1'b0;
        unique case (1'b1)
            (opc == OPC_LUI) || (opc == OPC_AUIPC): begin
                fmt   = FMT_U;
                imm32 = u_imm;
            end
            (opc == OPC_JAL): begin
                fmt   = FMT_J;
                imm32 = j_imm;
            end
            (opc == OPC_JALR) || (opc == OPC_LOAD) ||
            (opc == OPC_FENCE): begin
                fmt   = FMT_I;
                imm32 = i_imm;
            end
            (opc == OPC_OPIMM): begin
                fmt     = FMT_I;
                imm32   = i_imm;
                illegal = !RV64 && wide_shamt;
            end
            (opc == OPC_BRANCH): begin
                fmt   = FMT_B;
                imm32 = b_imm;
            end
            (opc == OPC_STORE): begin
                fmt   = FMT_S;
                imm32 = s_imm;
            end
            (opc == OPC_OP): begin
                fmt = FMT_R;
            end
            (opc == OPC_SYSTEM): begin
                fmt   = f3[2] ? FMT_Z : FMT_I;
                imm32 = f3[2] ? z_imm : i_imm;
            end
            (opc == OPC_OPIMM32): begin
                fmt     = FMT_I;
                imm32   = i_imm;
                illegal = !RV64;
            end
            (opc == OPC_OP32): begin
                fmt     = FMT_R;
                illegal = !RV64;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign imm = XLEN'(imm32);

endmodule

// File: rtl/immx_pipe.sv
// Registered immediate-extraction stage with optional two-entry skid
// buffer; decode happens on the input side, results are held in flops.
module immx_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int SKID  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_insn,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  dec_imm;
    imm_fmt_t         dec_fmt;
    logic             dec_ill;

    skid_state_t      state;
    skid_state_t      state_nx;
    logic             rdy_q;
    logic             acc;
    logic             dlv;
    logic             ld_out;
    logic             ld_skid;
    logic             mv_skid;

    logic [XLEN-1:0]  sk_imm;
    logic [2:0]       sk_fmt;
    logic             sk_ill;
    logic [TAG_W-1:0] sk_tag;

    imm_decode_core #(.XLEN(XLEN)) u_dec (
        .insn    (in_insn),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_ill)
    );

    assign out_valid = (state != SK_EMPTY);
    assign in_ready  = (SKID != 0) ? rdy_q : (!out_valid || out_ready);
    assign acc       = in_valid && in_ready;
    assign dlv       = out_valid && out_ready;

    // Occupancy next-state and register load strobes; flush wins
    always_comb begin
        state_nx = state;
        ld_out   = 1'b0;
        ld_skid  = 1'b0;
        mv_skid  = 1'b0;
        if (flush) begin
            state_nx = SK_EMPTY;
        end else begin
            case (state)
                SK_EMPTY: begin
                    if (acc) begin
                        state_nx = SK_ONE;
                        ld_out   = 1'b1;
                    end
                end
                SK_ONE: begin
                    if (acc && dlv) begin
                        ld_out = 1'b1;
                    end else if (acc) begin
                        state_nx = SK_TWO;
                        ld_skid  = 1'b1;
                    end else if (dlv) begin
                        state_nx = SK_EMPTY;
                    end
                end
                SK_TWO: begin
                    if (dlv) begin
                        state_nx = SK_ONE;
                        mv_skid  = 1'b1;
                    end
                end
                default: begin
                    state_nx = SK_EMPTY;
                end
            endcase
        end
    end

    // State register; in_ready flop is a pure function of next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SK_EMPTY;
            rdy_q <= 1'b1;
        end else begin
            state <= state_nx;
            rdy_q <= (state_nx != SK_TWO);
        end
    end

    // Output and skid data registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_imm     <= '0;
            out_fmt     <= '0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
            sk_imm      <= '0;
            sk_fmt      <= '0;
            sk_ill      <= 1'b0;
            sk_tag      <= '0;
        end else begin
            if (ld_out) begin
                out_imm     <= dec_imm;
                out_fmt     <= dec_fmt;
                out_illegal <= dec_ill;
                out_tag     <= in_tag;
            end else if (mv_skid) begin
                out_imm     <= sk_imm;
                out_fmt     <= sk_fmt;
                out_illegal <= sk_ill;
                out_tag     <= sk_tag;
            end
            if (ld_skid) begin
                sk_imm <= dec_imm;
                sk_fmt <= dec_fmt;
                sk_ill <= dec_ill;
                sk_tag <= in_tag;
            end
        end
    end

endmodule

// File: tb/tb_immx_pipe.sv
// Bench for immx_pipe: RV32 skid instance and RV64 no-skid instance
// share stimulus; each has its own queue-based reference scoreboard.
module tb_immx_pipe;

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_insn;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_ill;
    logic [31:0] a_out_imm;
    logic [2:0]  a_out_fmt;
    logic [31:0] a_out_tag;

    logic        b_in_ready, b_out_valid, b_out_ill;
    logic [63:0] b_out_imm;
    logic [2:0]  b_out_fmt;
    logic [31:0] b_out_tag;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t q32[$];
    exp_t q64[$];
    logic [31:0] d32[$];
    logic [31:0] d64[$];
    bit   rec = 1'b0;

    always #5 clk = ~clk;

    immx_pipe #(.XLEN(32), .TAG_W(32), .SKID(1)) u32 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_insn(in_insn), .in_tag(in_tag),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_imm(a_out_imm), .out_fmt(a_out_fmt),
        .out_illegal(a_out_ill), .out_tag(a_out_tag)
    );

    immx_pipe #(.XLEN(64), .TAG_W(32), .SKID(0)) u64 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_insn(in_insn), .in_tag(in_tag),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_imm(b_out_imm), .out_fmt(b_out_fmt),
        .out_illegal(b_out_ill), .out_tag(b_out_tag)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Immediate rules written as signed arithmetic on the whole word
    function automatic exp_t ref_dec(input logic [31:0] i,
                                     input bit rv64,
                                     input logic [31:0] tag);
        exp_t   e;
        longint s;
        longint v;
        s = longint'($signed(i));
        v = 0;
        e.fmt = 3'd0;
        e.ill = 1'b0;
        e.tag = tag;
        case (i[6:0])
            7'h37, 7'h17: begin e.fmt = 3'd4; v = (s >>> 12) * 4096; end
            7'h6F: begin
                e.fmt = 3'd5;
                v = (s >>> 31) * (1 << 20)
                  + longint'(i[19:12]) * 4096
                  + longint'(i[20]) * 2048
                  + longint'(i[30:21]) * 2;
            end
            7'h67, 7'h03, 7'h0F: begin e.fmt = 3'd1; v = s >>> 20; end
            7'h13: begin
                e.fmt = 3'd1;
                v = s >>> 20;
                e.ill = !rv64 && i[25] &&
                        (i[14:12] == 3'd1 || i[14:12] == 3'd5);
            end
            7'h63: begin
                e.fmt = 3'd3;
                v = (s >>> 31) * 4096 + longint'(i[7]) * 2048
                  + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
            end
            7'h23: begin
                e.fmt = 3'd2;
                v = (s >>> 25) * 32 + longint'(i[11:7]);
            end
            7'h33: e.fmt = 3'd0;
            7'h73: begin
                if (i[14]) begin e.fmt = 3'd6; v = longint'(i[19:15]); end
                else begin e.fmt = 3'd1; v = s >>> 20; end
            end
            7'h1B: begin e.fmt = 3'd1; v = s >>> 20; e.ill = !rv64; end
            7'h3B: begin e.fmt = 3'd0; e.ill = !rv64; end
            default: e.ill = 1'b1;
        endcase
        e.imm = 64'(v);
        if (!rv64) e.imm[63:32] = 32'h0;
        return e;
    endfunction

    // Scoreboard for the RV32 skid instance
    always @(negedge clk) begin
        if (reset || flush) begin
            q32.delete();
        end else begin
            chk("v32", 64'(a_out_valid), 64'(q32.size() != 0));
            chk("rdy32", 64'(a_in_ready), 64'(q32.size() < 2));
            if (a_out_valid && q32.size() != 0) begin
                chk("imm32", {32'h0, a_out_imm}, q32[0].imm);
                chk("fmt32", 64'(a_out_fmt), 64'(q32[0].fmt));
                chk("ill32", 64'(a_out_ill), 64'(q32[0].ill));
                chk("tag32", 64'(a_out_tag), 64'(q32[0].tag));
                if (out_ready) begin
                    if (rec) d32.push_back(a_out_tag);
                    void'(q32.pop_front());
                end
            end
            if (in_valid && a_in_ready)
                q32.push_back(ref_dec(in_insn, 1'b0, in_tag));
        end
    end

    // Scoreboard for the RV64 single-register instance
    always @(negedge clk) begin
        if (reset || flush) begin
            q64.delete();
        end else begin
            chk("v64", 64'(b_out_valid), 64'(q64.size() != 0));
            chk("rdy64", 64'(b_in_ready),
                64'(q64.size() == 0 || out_ready));
            if (b_out_valid && q64.size() != 0) begin
                chk("imm64", b_out_imm, q64[0].imm);
                chk("fmt64", 64'(b_out_fmt), 64'(q64[0].fmt));
                chk("ill64", 64'(b_out_ill), 64'(q64[0].ill));
                chk("tag64", 64'(b_out_tag), 64'(q64[0].tag));
                if (out_ready) begin
                    if (rec) d64.push_back(b_out_tag);
                    void'(q64.pop_front());
                end
            end
            if (in_valid && b_in_ready)
                q64.push_back(ref_dec(in_insn, 1'b1, in_tag));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] insn, input logic [31:0] tag);
        cyc();
        in_valid = 1'b1;
        in_insn  = insn;
        in_tag   = tag;
        cyc();
        in_valid = 1'b0;
    endtask

    logic [31:0] v_insn [6] = '{32'h123450B7, 32'hFFDFF0EF, 32'hFE20AE23,
                                32'h300FD073, 32'h0000007F, 32'h02009093};
    logic [63:0] v_imm64[6] = '{64'h12345000, 64'hFFFFFFFFFFFFFFFC,
                                64'hFFFFFFFFFFFFFFFC, 64'h1F, 64'h0, 64'h20};
    logic [2:0]  v_fmt  [6] = '{3'd4, 3'd5, 3'd2, 3'd6, 3'd0, 3'd1};
    logic        v_ill32[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        v_ill64[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [6:0]  opcs[13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                              7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h1B,
                              7'h3B};

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_insn = '0; in_tag = '0; out_ready = 1'b1;
        cyc(); cyc();
        chk("rst_v32", 64'(a_out_valid), 64'd0);
        chk("rst_rdy32", 64'(a_in_ready), 64'd1);
        chk("rst_imm32", 64'(a_out_imm), 64'd0);
        chk("rst_fmt32", 64'(a_out_fmt), 64'd0);
        chk("rst_ill32", 64'(a_out_ill), 64'd0);
        chk("rst_tag32", 64'(a_out_tag), 64'd0);
        chk("rst_v64", 64'(b_out_valid), 64'd0);
        reset = 1'b0;

        // Directed decode vectors, result visible right after accept
        for (int k = 0; k < 6; k++) begin
            send(v_insn[k], 32'(k + 100));
            chk("dir_v32", 64'(a_out_valid), 64'd1);
            if (k != 5) begin
                chk("dir_imm32", 64'(a_out_imm), {32'h0, v_imm64[k][31:0]});
                chk("dir_fmt32", 64'(a_out_fmt), 64'(v_fmt[k]));
            end
            chk("dir_ill32", 64'(a_out_ill), 64'(v_ill32[k]));
            chk("dir_imm64", b_out_imm, v_imm64[k]);
            chk("dir_fmt64", 64'(b_out_fmt), 64'(v_fmt[k]));
            chk("dir_ill64", 64'(b_out_ill), 64'(v_ill64[k]));
        end
        cyc(); cyc();

        // Backpressure: tags 1,2,3 against a stalled consumer
        d32.delete(); d64.delete(); rec = 1'b1;
        out_ready = 1'b0; in_valid = 1'b1; in_insn = 32'h00000013;
        in_tag = 32'd1; cyc();
        in_tag = 32'd2; cyc();
        in_tag = 32'd3;
        chk("bp_rdy32", 64'(a_in_ready), 64'd0);
        chk("bp_rdy64", 64'(b_in_ready), 64'd0);
        cyc(); cyc();
        chk("bp_hold_rdy32", 64'(a_in_ready), 64'd0);
        chk("bp_hold_tag32", 64'(a_out_tag), 64'd1);
        chk("bp_hold_tag64", 64'(b_out_tag), 64'd1);
        out_ready = 1'b1;
        cyc(); cyc();
        in_valid = 1'b0;
        cyc(); cyc(); cyc();
        rec = 1'b0;
        chk("bp_cnt32", 64'(d32.size()), 64'd3);
        for (int k = 0; k < 3 && k < d32.size(); k++)
            chk("bp_ord32", 64'(d32[k]), 64'(k + 1));
        chk("bp_first64", 64'(d64.size() != 0 ? d64[0] : 32'hDEAD), 64'd1);
        chk("bp_ret_rdy32", 64'(a_in_ready), 64'd1);

        // Flush with two entries held and a new input offered
        out_ready = 1'b0; in_valid = 1'b1;
        in_tag = 32'h10; cyc();
        in_tag = 32'h11; cyc();
        chk("fl_pre_rdy32", 64'(a_in_ready), 64'd0);
        flush = 1'b1; in_tag = 32'h12; cyc();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_v32", 64'(a_out_valid), 64'd0);
        chk("fl_v64", 64'(b_out_valid), 64'd0);
        chk("fl_rdy32", 64'(a_in_ready), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("fl_none32", 64'(a_out_valid), 64'd0);
        end

        // Asynchronous reset in mid-stream
        out_ready = 1'b0; in_valid = 1'b1;
        in_tag = 32'h20; cyc();
        in_tag = 32'h21; cyc();
        #1 reset = 1'b1; in_valid = 1'b0;
        #1;
        chk("ar_v32", 64'(a_out_valid), 64'd0);
        chk("ar_v64", 64'(b_out_valid), 64'd0);
        chk("ar_tag32", 64'(a_out_tag), 64'd0);
        cyc(); cyc();
        reset = 1'b0; out_ready = 1'b1;
        cyc();
        chk("ar_rdy32", 64'(a_in_ready), 64'd1);
        chk("ar_rdy64", 64'(b_in_ready), 64'd1);
        chk("ar_post_v32", 64'(a_out_valid), 64'd0);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            in_insn   = $urandom;
            begin
                int idx;
                idx = $urandom_range(0, 15);
                if (idx < 13) in_insn[6:0] = opcs[idx];
            end
            in_tag = $urandom;
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) cyc();
        chk("drain32", 64'(q32.size()), 64'd0);
        chk("drain64", 64'(q64.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
